// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS bit positions, receive FSM states.
package uart_pkg;

  localparam logic [31:0] UART_RX_DATA = 32'h0000_0000;
  localparam logic [31:0] UART_RX_STAT = 32'h0000_0004;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_OVERRUN   = 1;
  localparam int unsigned STAT_FRAME_ERR = 2;
  localparam int unsigned STAT_FULL      = 3;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  // Word index of a register byte offset, as seen on paddr[3:2].
  function automatic logic [1:0] reg_index(input logic [31:0] offset);
    return offset[3:2];
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: input synchroniser, framing FSM and shift register.
// Emits a one-cycle byte_valid / frame_err_pulse on the stop-bit sample edge.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_m;
  logic            rx_s;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            armed;
  logic [1:0]      fill;
  logic            stop_sample;

  // Two-flop synchroniser, idle-high reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_serial;
      rx_s <= rx_m;
    end
  end

  // Counts edges since reset so the reset value of the synchroniser is not
  // mistaken for the line having been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (fill != 2'd2) begin
      fill <= fill + 2'd1;
    end
  end

  // Framing FSM. A start edge is accepted only once armed, i.e. after rx_s
  // has been observed high in IDLE; this also blocks restarts after a
  // low stop bit until the line recovers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      armed   <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (armed && !rx_s) begin
            state   <= RX_START;
            armed   <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
          end else if (rx_s && fill == 2'd2) begin
            armed <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Results are combinational so the stop-sample edge is the push edge.
  always_comb begin
    stop_sample     = (state == RX_STOP) && (cnt == BIT_END);
    byte_valid      = stop_sample && rx_s;
    frame_err_pulse = stop_sample && !rx_s;
    byte_data       = shift;
  end

endmodule

// File: rtl/apb_uart_rx.sv
// APB UART receiver: receive FIFO, DATA/STATUS registers, sticky error flags
// and a level interrupt while data is pending.
module apb_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        rx_serial,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err_pulse;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          overrun;
  logic          frame_err;

  logic          rd_acc;
  logic          wr_acc;
  logic [1:0]    reg_sel;
  logic          sel_data;
  logic          sel_stat;
  logic          not_empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovr_set;
  logic          clr_ovr;
  logic          clr_ferr;
  logic [3:0]    status;
  logic          unused;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk             (clk),
    .rst             (rst),
    .rx_serial       (rx_serial),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (frame_err_pulse)
  );

  assign unused = ^{paddr[31:4], paddr[1:0], pwdata[31:3], pwdata[0]};

  // APB decode and FIFO control; a pop frees a slot for a same-cycle push.
  always_comb begin
    rd_acc    = psel && penable && !pwrite;
    wr_acc    = psel && penable && pwrite;
    reg_sel   = paddr[3:2];
    sel_data  = (reg_sel == reg_index(UART_RX_DATA));
    sel_stat  = (reg_sel == reg_index(UART_RX_STAT));
    not_empty = (count != '0);
    full      = (count == FULL_CNT);
    pop       = rd_acc && sel_data && not_empty;
    push_ok   = byte_valid && (!full || pop);
    ovr_set   = byte_valid && full && !pop;
    clr_ovr   = wr_acc && sel_stat && pwdata[STAT_OVERRUN];
    clr_ferr  = wr_acc && sel_stat && pwdata[STAT_FRAME_ERR];
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push_ok) begin
      count_next = count - 1'b1;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= byte_data;
    end
  end

  // FIFO pointers, occupancy and the registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      irq   <= (count_next != '0);
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
      if (frame_err_pulse) begin
        frame_err <= 1'b1;
      end else if (clr_ferr) begin
        frame_err <= 1'b0;
      end
    end
  end

  // Zero-wait-state read mux, driven only during a read access.
  always_comb begin
    status                 = '0;
    status[STAT_NOT_EMPTY] = not_empty;
    status[STAT_OVERRUN]   = overrun;
    status[STAT_FRAME_ERR] = frame_err;
    status[STAT_FULL]      = full;
    pready = psel && penable;
    prdata = '0;
    if (rd_acc) begin
      if (sel_data && not_empty) begin
        prdata = {24'b0, mem[rd_ptr]};
      end else if (sel_stat) begin
        prdata = {28'b0, status};
      end
    end
  end

endmodule
